// File: rtl/quadrature_input_decoder.sv
// quadrature_input_decoder
//   Front end for the encoder-driven PWM stage. Each raw encoder pin passes
//   through a two-flop synchroniser and a debounce filter. The filtered code
//   {a_filt,b_filt} is decoded into one-cycle step pulses with a direction,
//   and a wrap-around signed position count is kept.
//
//   Optional feature macro: QUAD_X4_EN
//     defined   : x4 decoding, every legal transition is a step.
//     undefined : x1 decoding, a step only on entry into code 00
//                 (from 10 = up, from 01 = down).
//
//   Output protocol: step_valid is a single-cycle pulse with no backpressure.
//   step_up is valid whenever step_valid is high and holds its value until
//   the next step. position and err_flag update on the same edge as
//   step_valid. dbg_state exposes the decoder FSM (0 = UNPRIMED, 1 = RUN).
module quadrature_input_decoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int POS_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enc_a_raw,
   input  logic                 enc_b_raw,
   input  logic                 pos_clr,
   input  logic                 err_clr,
   output logic                 step_valid,
   output logic                 step_up,
   output logic [POS_WIDTH-1:0] position,
   output logic                 err_flag,
   output logic                 a_filt,
   output logic                 b_filt,
   output logic                 dbg_state
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Priming window covers the full sync + filter pipeline so that whatever
   // code the pins sit at after reset reaches prev before decoding starts.
   localparam int PRIME_CYCLES = 3 + DEBOUNCE_CYCLES;
   localparam int SET_W        = $clog2(PRIME_CYCLES + 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(PRIME_CYCLES - 1);

   typedef enum logic {
      ST_UNPRIMED = 1'b0,
      ST_RUN      = 1'b1
   } dec_state_t;

   logic [1:0]       a_sync;
   logic [1:0]       b_sync;
   logic [CNT_W-1:0] a_cnt;
   logic [CNT_W-1:0] b_cnt;

   dec_state_t       state_q;
   dec_state_t       state_d;
   logic [SET_W-1:0] settle_q;
   logic [SET_W-1:0] settle_d;
   logic [1:0]       prev_q;
   logic [1:0]       cur_code;

   logic             legal;
   logic             illegal;
   logic             dir_up;
   logic             fire;

   assign cur_code  = {a_filt, b_filt};
   assign dbg_state = state_q;

   // Two-flop synchronisers for the asynchronous encoder pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync <= 2'b00;
         b_sync <= 2'b00;
      end else begin
         a_sync <= {a_sync[0], enc_a_raw};
         b_sync <= {b_sync[0], enc_b_raw};
      end
   end

   // Channel A debounce: accept a new level after DEBOUNCE_CYCLES stable clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cnt  <= '0;
         a_filt <= 1'b0;
      end else if (a_sync[1] == a_filt) begin
         a_cnt <= '0;
      end else if (a_cnt == DB_LAST) begin
         a_filt <= a_sync[1];
         a_cnt  <= '0;
      end else begin
         a_cnt <= a_cnt + CNT_W'(1);
      end
   end

   // Channel B debounce: same filter, fully independent of channel A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_cnt  <= '0;
         b_filt <= 1'b0;
      end else if (b_sync[1] == b_filt) begin
         b_cnt <= '0;
      end else if (b_cnt == DB_LAST) begin
         b_filt <= b_sync[1];
         b_cnt  <= '0;
      end else begin
         b_cnt <= b_cnt + CNT_W'(1);
      end
   end

   // Decoder FSM state, settle counter and previous-code registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_UNPRIMED;
         settle_q <= '0;
         prev_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         prev_q   <= cur_code;
      end
   end

   // Next state and transition classification (defaults first).
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      legal    = 1'b0;
      illegal  = 1'b0;
      dir_up   = 1'b0;
      fire     = 1'b0;
      case (state_q)
         ST_UNPRIMED: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_RUN;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_RUN: begin
            // {prev, cur}: up order is 00 -> 01 -> 11 -> 10 -> 00.
            case ({prev_q, cur_code})
               4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                  legal  = 1'b1;
                  dir_up = 1'b1;
               end
               4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                  legal = 1'b1;
               end
               4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                  illegal = 1'b1;
               end
               default: ;
            endcase
         end
         default: begin
            state_d = ST_UNPRIMED;
         end
      endcase
`ifdef QUAD_X4_EN
      fire = legal;
`else
      fire = legal && (cur_code == 2'b00);
`endif
   end

   // Step pulse and held direction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_valid <= 1'b0;
         step_up    <= 1'b0;
      end else begin
         step_valid <= fire;
         if (fire) begin
            step_up <= dir_up;
         end
      end
   end

   // Wrap-around position count; a coincident clear beats the step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position <= '0;
      end else if (pos_clr) begin
         position <= '0;
      end else if (fire) begin
         if (dir_up) begin
            position <= position + POS_WIDTH'(1);
         end else begin
            position <= position - POS_WIDTH'(1);
         end
      end
   end

   // Sticky illegal-transition flag; a coincident set beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag <= 1'b0;
      end else if (illegal) begin
         err_flag <= 1'b1;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quadrature_input_decoder.sv
// Bench for quadrature_input_decoder. Reference model works on the raw pin
// codes: each code is placed on a ring (00,01,11,10) and the ring distance
// between old and new code decides none / up / down / illegal.
module tb_quadrature_input_decoder;

  localparam int DEB = 4;
  localparam int PW  = 8;
  localparam int LAT = 3 + DEB;
  localparam int MOD = 1 << PW;

`ifdef QUAD_X4_EN
  localparam logic [PW-1:0] UP_POS   = 8'd4;
  localparam logic [PW-1:0] DOWN_POS = 8'hFC;
`else
  localparam logic [PW-1:0] UP_POS   = 8'd1;
  localparam logic [PW-1:0] DOWN_POS = 8'hFF;
`endif

  logic          clk;
  logic          rst_n;
  logic          enc_a_raw;
  logic          enc_b_raw;
  logic          pos_clr;
  logic          err_clr;
  logic          step_valid;
  logic          step_up;
  logic [PW-1:0] position;
  logic          err_flag;
  logic          a_filt;
  logic          b_filt;
  logic          dbg_state;

  quadrature_input_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .POS_WIDTH       (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a_raw  (enc_a_raw),
    .enc_b_raw  (enc_b_raw),
    .pos_clr    (pos_clr),
    .err_clr    (err_clr),
    .step_valid (step_valid),
    .step_up    (step_up),
    .position   (position),
    .err_flag   (err_flag),
    .a_filt     (a_filt),
    .b_filt     (b_filt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [PW:0] exp_q[$];  // {step_up, position after step}
  logic [1:0]  m_code;
  int          m_pos;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ring_idx(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring_code(input int i);
    logic [1:0] tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    return tbl[i % 4];
  endfunction

  function automatic int ring_delta(input logic [1:0] o, input logic [1:0] n);
    return (ring_idx(n) - ring_idx(o) + 4) % 4;
  endfunction

  function automatic bit will_step(input logic [1:0] o, input logic [1:0] n);
    int d;
    d = ring_delta(o, n);
`ifdef QUAD_X4_EN
    return (d == 1) || (d == 3);
`else
    return ((d == 1) || (d == 3)) && (n == 2'b00);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Drive a new raw code, hold it, and check the step/err/position outcome.
  task automatic apply_code(input logic [1:0] nc, input int hold, input bit arm_pos, input bit arm_err);
    int   d;
    bit   stp;
    bit   ill;
    bit   up;
    int   pulses;
    int   first_edge;
    logic [PW:0] rec;
    d   = ring_delta(m_code, nc);
    stp = will_step(m_code, nc);
    ill = (d == 2);
    up  = (d == 1);
    if (stp) begin
      if (arm_pos) m_pos = 0;
      else         m_pos = (m_pos + (up ? 1 : MOD - 1)) % MOD;
      exp_q.push_back({up, PW'(m_pos)});
    end
    if (ill) m_err = 1'b1;
    m_code = nc;
    pulses = 0;
    first_edge = 0;
    @(negedge clk);
    {enc_a_raw, enc_b_raw} = nc;
    for (int e = 1; e <= hold; e++) begin
      @(posedge clk);
      #1;
      if (step_valid) begin
        pulses++;
        if (first_edge == 0) first_edge = e;
        if (exp_q.size() > 0) begin
          rec = exp_q.pop_front();
          check("step_dir", step_up, rec[PW]);
          check("step_pos", position, rec[PW-1:0]);
        end else begin
          check("spurious_step", step_valid, 1'b0);
        end
      end
      if (e == LAT - 1) begin
        pos_clr = arm_pos && stp;
        err_clr = arm_err && ill;
      end
      if (e == LAT) begin
        pos_clr = 1'b0;
        err_clr = 1'b0;
      end
    end
    check("pulse_count", pulses, stp ? 1 : 0);
    if (stp) check("step_latency", first_edge, LAT);
    check("pos_after", position, m_pos);
    check("err_after", err_flag, m_err);
    check("a_filt_after", a_filt, nc[1]);
    check("b_filt_after", b_filt, nc[0]);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pos_clear();
    @(negedge clk);
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    m_pos = 0;
    check("pos_clr", position, 0);
  endtask

  task automatic err_clear();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", err_flag, 1'b0);
  endtask

  // Short A glitches (3 clocks) with B low must be swallowed by the filter.
  task automatic bounce_a();
    int pre;
    pre = m_pos;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      enc_a_raw = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
        check("bounce_afilt", a_filt, 1'b0);
        check("bounce_step", step_valid, 1'b0);
      end
      @(negedge clk);
      enc_a_raw = 1'b0;
      repeat (6) begin
        @(posedge clk);
        #1;
        check("bounce_afilt", a_filt, 1'b0);
        check("bounce_step", step_valid, 1'b0);
      end
    end
    check("bounce_pos", position, pre);
  endtask

  // Reset hits while a new code is still in the pipeline.
  task automatic reset_mid(input logic [1:0] nc);
    @(negedge clk);
    {enc_a_raw, enc_b_raw} = nc;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_step_valid", step_valid, 1'b0);
    check("rst_step_up", step_up, 1'b0);
    check("rst_position", position, 0);
    check("rst_err", err_flag, 1'b0);
    check("rst_a_filt", a_filt, 1'b0);
    check("rst_b_filt", b_filt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("reprime_step", step_valid, 1'b0);
      check("reprime_err", err_flag, 1'b0);
    end
    check("reprime_a", a_filt, nc[1]);
    check("reprime_b", b_filt, nc[0]);
    m_code = nc;
    m_pos  = 0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pre;
    logic [1:0] nx;
    rst_n = 1'b0;
    enc_a_raw = 1'b0;
    enc_b_raw = 1'b0;
    pos_clr = 1'b0;
    err_clr = 1'b0;
    m_code = 2'b00;
    m_pos = 0;
    m_err = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_step_valid", step_valid, 1'b0);
    check("reset_step_up", step_up, 1'b0);
    check("reset_position", position, 0);
    check("reset_err", err_flag, 1'b0);
    check("reset_a_filt", a_filt, 1'b0);
    check("reset_b_filt", b_filt, 1'b0);
    check("reset_state", dbg_state, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      check("idle_step", step_valid, 1'b0);
    end
    check("idle_pos", position, 0);
    check("idle_err", err_flag, 1'b0);

    // Reset with pins parked at 11: priming must hide the 00 -> 11 jump.
    @(negedge clk);
    rst_n = 1'b0;
    enc_a_raw = 1'b1;
    enc_b_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      check("prime11_step", step_valid, 1'b0);
      check("prime11_err", err_flag, 1'b0);
    end
    check("prime11_a", a_filt, 1'b1);
    check("prime11_b", b_filt, 1'b1);
    m_code = 2'b11;
    apply_code(2'b10, 12, 0, 0);
    apply_code(2'b00, 12, 0, 0);

    // One full up cycle.
    pos_clear();
    apply_code(2'b01, 20, 0, 0);
    apply_code(2'b11, 20, 0, 0);
    apply_code(2'b10, 20, 0, 0);
    apply_code(2'b00, 20, 0, 0);
    check("up_cycle_pos", position, UP_POS);

    // One full down cycle.
    pos_clear();
    apply_code(2'b10, 20, 0, 0);
    apply_code(2'b11, 20, 0, 0);
    apply_code(2'b01, 20, 0, 0);
    apply_code(2'b00, 20, 0, 0);
    check("down_cycle_pos", position, DOWN_POS);

    // Glitch rejection, then a real A edge.
    bounce_a();
    apply_code(2'b10, 20, 0, 0);
    apply_code(2'b00, 20, 0, 0);

    // Illegal transitions and err_clr priority.
    pre = m_pos;
    apply_code(2'b11, 20, 0, 0);
    check("illegal_err", err_flag, 1'b1);
    check("illegal_pos", position, pre);
    err_clear();
    apply_code(2'b00, 20, 0, 1);
    check("err_set_wins", err_flag, 1'b1);
    err_clear();

    // Walk up to position 5, then clear coincident with a step.
    pos_clear();
    while (m_pos != 5) apply_code(ring_code(ring_idx(m_code) + 1), 10, 0, 0);
    check("pos_at_5", position, 5);
    for (int k = 0; k < 4; k++) begin
      nx = ring_code(ring_idx(m_code) + 1);
      if (will_step(m_code, nx)) begin
        apply_code(nx, 12, 1, 0);
        break;
      end
      apply_code(nx, 10, 0, 0);
    end
    check("clr_wins_pos", position, 0);

    // Random code sequence including illegal jumps and coincident clears.
    for (int i = 0; i < 40; i++) begin
      apply_code(2'($urandom_range(0, 3)), $urandom_range(8, 16),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of a sequence.
    reset_mid(ring_code(ring_idx(m_code) + 1));
    for (int i = 0; i < 10; i++) begin
      apply_code(2'($urandom_range(0, 3)), $urandom_range(8, 16), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_input_decoder.md
Name: quadrature_input_decoder

Overview:
- Upstream front-end for the encoder-driven PWM stage.
- Synchronises and debounces the raw encoder A/B pins, decodes quadrature transitions into one-cycle step pulses with direction, and keeps a signed wrap-around position count.
- The step pulse and direction feed the duty-cycle logic downstream in place of raw pin edges.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable clocks a synchronised channel needs before its filtered value updates (legal values >= 1).
- POS_WIDTH, 8, width of the two's-complement position counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- enc_a_raw  input  1  raw encoder channel A, asynchronous to clk.
- enc_b_raw  input  1  raw encoder channel B, asynchronous to clk.
- pos_clr  input  1  synchronous clear of position.
- err_clr  input  1  synchronous clear of err_flag.
- step_valid  output  1  one-cycle pulse per decoded step.
- step_up  output  1  direction for the current step_valid (1 = up/CW, 0 = down/CCW); held until the next step.
- position  output  POS_WIDTH  signed step count.
- err_flag  output  1  sticky illegal-transition flag.
- a_filt  output  1  debounced A.
- b_filt  output  1  debounced B.

Behaviour:
- Reset (rst_n low, async) clears the following to 0: all synchroniser FFs, debounce counters, a_filt/b_filt, prev state, settle counter, step_valid, step_up, position, err_flag. Decoder enters UNPRIMED.
- Synchroniser: two FFs per channel.
- Debounce, per channel, independent: counter increments while sync != filt and clears when equal. When the counter is DEBOUNCE_CYCLES-1 and the values still differ, filt <= sync and the counter clears. Any bounce shorter than DEBOUNCE_CYCLES clocks is absorbed.
- Latency: a raw change held stable yields step_valid high exactly 3+DEBOUNCE_CYCLES rising edges later (2 sync + DEBOUNCE_CYCLES filter + 1 decode).
- Decoder state code is {a_filt,b_filt}. Up sequence is 00->01->11->10->00; down is the reverse. B leads A for up.
- Decoder states:
  - UNPRIMED: for 3+DEBOUNCE_CYCLES clocks after reset release, prev <= filt every cycle, with no steps and no errors. Then go to RUN.
  - RUN: each cycle compare filt against prev, then prev <= filt.
    - No change: nothing happens.
    - One bit changed: legal transition; direction from the table.
    - Both bits changed: illegal. err_flag <= 1; no step; position unchanged.
- Step counting: up steps add 1 to position, down steps subtract 1, modulo 2^POS_WIDTH with no saturation (0 - 1 = all-ones).
- step_valid is a single registered cycle per step. step_up updates in the same cycle as step_valid.
- pos_clr: position <= 0 next cycle. If a step occurs in the same cycle, the clear wins and position = 0. step_valid/step_up still report that step.
- err_clr: err_flag <= 0. If an illegal transition occurs in the same cycle, set wins and err_flag stays 1.
- Reset mid-operation: all state is dropped immediately. After release the decoder re-primes, so pins sitting at a non-00 code never produce a spurious step or error.

Optional Feature:
- Macro QUAD_X4_EN.
- Defined: x4 decoding; every legal transition produces a step (4 per detent cycle).
- Undefined: x1 decoding; step only on entry into 00 (from 10 = up, from 01 = down). Other legal transitions update prev silently. Illegal-transition detection and the error rules are identical in both modes.

Test Plan:
- Common setup: DEBOUNCE_CYCLES=4, POS_WIDTH=8.
- Reset with pins 00, release, idle 50 clks -> step_valid never asserts, position=0, err_flag=0. Assert reset with pins at 11, release -> no step, no error after priming.
- One full up cycle 00->01->11->10->00, each phase held 20 clks -> X4: four pulses, step_up=1, position=8'd4. x1: one pulse, position=8'd1. First pulse appears exactly 7 edges after the first raw change.
- From position 0, one full down cycle -> X4: position=8'hFC. x1: position=8'hFF. step_up=0 on every pulse.
- A pulses high 3 clks then returns low, repeated 5 times, B=0 -> a_filt stays 0, no step_valid, position unchanged. Hold A high 4+ clks -> exactly one step (X4).
- Both raw pins change 00->11 in the same clock and are held -> err_flag=1, no step, position unchanged. err_clr pulse -> err_flag=0. err_clr coincident with a new illegal transition -> err_flag stays 1.
- pos_clr asserted in the same cycle as a step_valid with position=8'd5 -> position=0 next cycle. Async rst_n pulse during a cycle sequence -> all outputs 0 immediately; no step for 7 clks after release.
